// File: rtl/bridge_replay_master.sv
// Replays a table of (address, data) writes onto the APF bridge register bus in the clk_74a domain.
// Optional read-back compare of each entry is enabled by defining BRIDGE_REPLAY_VERIFY_EN.
module bridge_replay_master #(
  parameter  int N_ENTRIES  = 16,
  parameter  int GAP_CYCLES = 16,
  localparam int IDX_W      = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
  input  logic              clk_74a,
  input  logic              reset_n,
  input  logic              start,
  output logic [IDX_W-1:0]  tbl_addr,
  input  logic [63:0]       tbl_data,
  input  logic              tbl_verify,
  output logic [31:0]       bridge_addr,
  output logic              bridge_wr,
  output logic [31:0]       bridge_wr_data,
  output logic              bridge_rd,
  input  logic [31:0]       bridge_rd_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [IDX_W-1:0]  err_index
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, WRITE, READ, RDWAIT, GAP, DONE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [GAP_W-1:0] gap_cnt;

  // The index register doubles as the table read address, so the ROM sees it during FETCH.
  assign tbl_addr = idx;

`ifdef BRIDGE_REPLAY_VERIFY_EN
  logic [31:0] ent_data;
  logic        ent_verify;

  // Entry payload is plain data and carries no reset.
  always_ff @(posedge clk_74a) begin
    if (state == LOAD) begin
      ent_data   <= tbl_data[31:0];
      ent_verify <= tbl_verify;
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{tbl_verify, bridge_rd_data};
  assign bridge_rd     = 1'b0;
  assign error         = 1'b0;
  assign err_index     = '0;
`endif

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      idx            <= '0;
      gap_cnt        <= '0;
      bridge_addr    <= '0;
      bridge_wr      <= 1'b0;
      bridge_wr_data <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
`ifdef BRIDGE_REPLAY_VERIFY_EN
      bridge_rd      <= 1'b0;
      error          <= 1'b0;
      err_index      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx   <= '0;
            busy  <= 1'b1;
            state <= FETCH;
`ifdef BRIDGE_REPLAY_VERIFY_EN
            error     <= 1'b0;
            err_index <= '0;
`endif
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          // A zero address terminates the table early.
          if (tbl_data[63:32] == 32'h0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            bridge_wr      <= 1'b1;
            bridge_addr    <= tbl_data[63:32];
            bridge_wr_data <= tbl_data[31:0];
            state          <= WRITE;
          end
        end
        WRITE: begin
          bridge_wr      <= 1'b0;
          bridge_wr_data <= '0;
`ifdef BRIDGE_REPLAY_VERIFY_EN
          if (ent_verify) begin
            bridge_rd <= 1'b1;
            state     <= READ;
          end else begin
            bridge_addr <= '0;
            gap_cnt     <= '0;
            state       <= GAP;
          end
`else
          bridge_addr <= '0;
          gap_cnt     <= '0;
          state       <= GAP;
`endif
        end
`ifdef BRIDGE_REPLAY_VERIFY_EN
        READ: begin
          bridge_rd <= 1'b0;
          state     <= RDWAIT;
        end
        RDWAIT: begin
          // Only the first mismatch of a run is recorded.
          if ((bridge_rd_data != ent_data) && !error) begin
            error     <= 1'b1;
            err_index <= idx;
          end
          bridge_addr <= '0;
          gap_cnt     <= '0;
          state       <= GAP;
        end
`endif
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (idx == LAST_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= FETCH;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bridge_replay_master.sv
// Scoreboard bench for bridge_replay_master: a table-walking model predicts every strobe, busy window and done pulse.
`timescale 1ns/1ps
module tb_bridge_replay_master;
  localparam int N  = 4;
  localparam int G  = 4;
  localparam int IW = 2;
`ifdef BRIDGE_REPLAY_VERIFY_EN
  localparam bit VERIFY_BUILD = 1'b1;
`else
  localparam bit VERIFY_BUILD = 1'b0;
`endif

  logic          clk_74a = 1'b0;
  logic          reset_n;
  logic          start;
  logic [IW-1:0] tbl_addr;
  logic [63:0]   tbl_data;
  logic          tbl_verify;
  logic [31:0]   bridge_addr;
  logic          bridge_wr;
  logic [31:0]   bridge_wr_data;
  logic          bridge_rd;
  logic [31:0]   bridge_rd_data;
  logic          busy;
  logic          done;
  logic          error;
  logic [IW-1:0] err_index;

  bridge_replay_master #(.N_ENTRIES(N), .GAP_CYCLES(G)) dut (
    .clk_74a(clk_74a), .reset_n(reset_n), .start(start),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data), .tbl_verify(tbl_verify),
    .bridge_addr(bridge_addr), .bridge_wr(bridge_wr), .bridge_wr_data(bridge_wr_data),
    .bridge_rd(bridge_rd), .bridge_rd_data(bridge_rd_data),
    .busy(busy), .done(done), .error(error), .err_index(err_index)
  );

  always #5 clk_74a = ~clk_74a;

  typedef struct {int cyc; logic [31:0] addr; logic [31:0] data;} acc_t;
  typedef struct {int cyc; bit err; int eidx;} done_t;

  acc_t  exp_wr[$];
  acc_t  exp_rd[$];
  done_t exp_done[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int busy_lo = 0;
  int busy_hi = 0;
  int rdwait_cyc = -1;
  int gap2_cyc = -1;
  logic [31:0] rdwait_addr = '0;
  bit mon_en = 1'b0;

  logic [31:0] tbl_a [N];
  logic [31:0] tbl_d [N];
  bit          tbl_v [N];
  logic [31:0] corrupt_addr = '0;
  logic [31:0] last_wr = '0;

  always @(posedge clk_74a) cyc <= cyc + 1;

  // Synchronous table ROM: data follows tbl_addr by one cycle.
  always @(posedge clk_74a) begin
    tbl_data   <= {tbl_a[tbl_addr], tbl_d[tbl_addr]};
    tbl_verify <= tbl_v[tbl_addr];
  end

  // Responder: read returns the last written word, flipped in bit 0 for the faulty address; noise otherwise.
  always @(posedge clk_74a) begin
    if (bridge_wr) last_wr <= bridge_wr_data;
    if (bridge_rd) bridge_rd_data <= last_wr ^ {31'b0, (bridge_addr == corrupt_addr)};
    else           bridge_rd_data <= $urandom;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: walk the table, each entry costs FETCH+LOAD+WRITE (+READ+RDWAIT) + gap.
  task automatic build_expect(input int k);
    int t; int done_c; bit e; int ei; bit v;
    t = k; done_c = -1; e = 1'b0; ei = 0; gap2_cyc = -1;
    for (int i = 0; i < N; i++) begin
      if (tbl_a[i] == 32'h0) begin
        done_c = t + 2;
        break;
      end
      exp_wr.push_back('{cyc: t + 2, addr: tbl_a[i], data: tbl_d[i]});
      v = VERIFY_BUILD && tbl_v[i];
      if (v) begin
        exp_rd.push_back('{cyc: t + 3, addr: tbl_a[i], data: tbl_d[i]});
        if (tbl_a[i] == corrupt_addr && !e) begin
          e = 1'b1;
          ei = i;
        end
      end
      if (i == 2) gap2_cyc = t + 3 + (v ? 2 : 0) + 1;
      t = t + 3 + (v ? 2 : 0) + G;
    end
    if (done_c < 0) done_c = t;
    exp_done.push_back('{cyc: done_c, err: e, eidx: ei});
    busy_lo = k;
    busy_hi = done_c;
  endtask

  acc_t  m_a;
  done_t m_d;
  bit    m_ew, m_er, m_ed;

  always @(negedge clk_74a) begin
    if (mon_en) begin
      m_ew = (exp_wr.size() != 0) && (exp_wr[0].cyc == cyc);
      m_er = (exp_rd.size() != 0) && (exp_rd[0].cyc == cyc);
      m_ed = (exp_done.size() != 0) && (exp_done[0].cyc == cyc);
      check("wr_strobe", 64'(bridge_wr), 64'(m_ew));
      check("rd_strobe", 64'(bridge_rd), 64'(m_er));
      check("done_pulse", 64'(done), 64'(m_ed));
      check("busy", 64'(busy), 64'((cyc >= busy_lo) && (cyc < busy_hi)));
      if (m_ew) begin
        m_a = exp_wr.pop_front();
        check("wr_addr", 64'(bridge_addr), 64'(m_a.addr));
        check("wr_data", 64'(bridge_wr_data), 64'(m_a.data));
      end else if (m_er) begin
        m_a = exp_rd.pop_front();
        check("rd_addr", 64'(bridge_addr), 64'(m_a.addr));
        rdwait_cyc  = cyc + 1;
        rdwait_addr = m_a.addr;
      end else if (cyc == rdwait_cyc) begin
        check("rdwait_addr", 64'(bridge_addr), 64'(rdwait_addr));
      end else begin
        check("idle_addr", 64'(bridge_addr), 64'(0));
      end
      if (m_ed) begin
        m_d = exp_done.pop_front();
        check("err_flag", 64'(error), 64'(m_d.err));
        check("err_index", 64'(err_index), 64'(m_d.eidx));
      end
      if (cyc == busy_lo) begin
        check("err_clear_on_start", 64'(error), 64'(0));
        check("err_index_clear_on_start", 64'(err_index), 64'(0));
      end
    end
  end

  task automatic issue_start();
    @(negedge clk_74a);
    start = 1'b1;
    build_expect(cyc + 1);
    @(negedge clk_74a);
    start = 1'b0;
  endtask

  task automatic run_table(input bit mid_start, input bit done_start);
    int done_c; int n;
    issue_start();
    done_c = busy_hi;
    if (mid_start && gap2_cyc > 0) begin
      while (cyc < gap2_cyc - 1) @(negedge clk_74a);
      start = 1'b1;
      @(negedge clk_74a);
      start = 1'b0;
    end
    if (done_start) begin
      while (cyc < done_c) @(negedge clk_74a);
      start = 1'b1;
      @(negedge clk_74a);
      start = 1'b0;
      repeat (20) @(negedge clk_74a);
    end
    n = 0;
    while (exp_done.size() != 0 && n < 500) begin
      @(negedge clk_74a);
      n++;
    end
    check("done_reached", 64'(exp_done.size()), 64'(0));
    repeat (3) @(negedge clk_74a);
  endtask

  task automatic set_directed(input bit verify_all);
    tbl_a[0] = 32'hF100_0000; tbl_d[0] = 32'h1234_5678;
    tbl_a[1] = 32'hF300_0000; tbl_d[1] = 32'h0000_ABCD;
    tbl_a[2] = 32'hF700_0000; tbl_d[2] = 32'h0000_0283;
    tbl_a[3] = 32'hF200_0000; tbl_d[3] = 32'h0000_0001;
    for (int i = 0; i < N; i++) tbl_v[i] = verify_all;
  endtask

  task automatic set_random();
    logic [31:0] a;
    for (int i = 0; i < N; i++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h0;
      else if (a == 32'h0) a = 32'h1;
      tbl_a[i] = a;
      tbl_d[i] = $urandom;
      tbl_v[i] = 1'($urandom_range(0, 1));
    end
    corrupt_addr = ($urandom_range(0, 1) == 1) ? tbl_a[$urandom_range(0, N - 1)] : 32'h0;
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    start   = 1'b0;
    for (int i = 0; i < N; i++) begin
      tbl_a[i] = '0; tbl_d[i] = '0; tbl_v[i] = 1'b0;
    end
    repeat (3) @(negedge clk_74a);
    reset_n = 1'b1;
    @(negedge clk_74a);
    check("reset_ctrl", 64'({bridge_wr, bridge_rd, busy, done, error}), 64'(0));
    check("reset_idx", 64'({tbl_addr, err_index}), 64'(0));
    check("reset_bus", 64'({bridge_addr, bridge_wr_data}), 64'(0));
    #1 mon_en = 1'b1;
    repeat (100) @(negedge clk_74a);

    // Directed table, no read-back.
    set_directed(1'b0);
    run_table(1'b0, 1'b0);

    // Table terminated at entry 1.
    tbl_a[1] = 32'h0;
    run_table(1'b0, 1'b0);

    // Read-back on every entry, F3000000 answers with bit 0 flipped; stray starts in GAP and DONE.
    set_directed(1'b1);
    corrupt_addr = 32'hF300_0000;
    run_table(1'b1, 1'b1);

    // Fresh start from IDLE clears the sticky error.
    corrupt_addr = 32'h0;
    run_table(1'b0, 1'b0);

    for (int r = 0; r < 25; r++) begin
      set_random();
      run_table(1'b0, 1'b0);
    end

    // Asynchronous reset landing in a WRITE cycle.
    set_directed(1'b0);
    corrupt_addr = 32'h0;
    issue_start();
    n = 0;
    while (!bridge_wr && n < 50) begin
      @(negedge clk_74a);
      n++;
    end
    check("reach_write", 64'(bridge_wr), 64'(1));
    #2 mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    check("async_wr_drop", 64'(bridge_wr), 64'(0));
    check("async_busy_drop", 64'(busy), 64'(0));
    check("async_addr_drop", 64'(bridge_addr), 64'(0));
    exp_wr.delete();
    exp_rd.delete();
    exp_done.delete();
    busy_lo = 0;
    busy_hi = 0;
    rdwait_cyc = -1;
    repeat (2) @(negedge clk_74a);
    reset_n = 1'b1;
    #1 mon_en = 1'b1;
    repeat (30) @(negedge clk_74a);
    check("post_reset_tbl_addr", 64'(tbl_addr), 64'(0));

    set_random();
    run_table(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
